// File: rtl/set_bit_enumerator_pkg.sv
// Shared types and defaults for the set-bit enumerator.
// State encoding and default mask geometry.
package set_bit_enumerator_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    ZERO = 2'd2
  } state_e;

endpackage

// File: rtl/set_bit_enumerator_lsb_encoder32.sv
// Lowest-set-bit priority encoder with single-bit detect.
// Purely combinational; idx_o is 0 for an all-zero vector.
module lsb_encoder32 #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 5
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             one_hot_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_comb begin
    idx_o = '0;
    // Scan downward so the lowest set bit wins.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign one_hot_o = (vec_i != '0) &&
                     ((vec_i & (vec_i - ONE)) == '0);

endmodule

// File: rtl/set_bit_enumerator.sv
// Splits a merged mask into set-bit indices, lowest first,
// one per output handshake; zero masks yield a single empty beat.
module set_bit_enumerator
  import set_bit_enumerator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_empty,
  output logic [IDX_W:0]   out_seq
);

  localparam logic [WIDTH-1:0] PEND_ONE = WIDTH'(1);
  localparam logic [IDX_W:0]   SEQ_ONE  = (IDX_W+1)'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pend_q, pend_d;
  logic [IDX_W:0]     seq_q, seq_d;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_one_hot;

  lsb_encoder32 #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec_i     (pend_q),
    .idx_o     (enc_idx),
    .one_hot_o (enc_one_hot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      seq_q   <= seq_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    seq_d     = seq_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_empty = 1'b0;
    out_seq   = '0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_mask != '0) begin
            pend_d  = in_mask;
            seq_d   = '0;
            state_d = EMIT;
          end else begin
            state_d = ZERO;
          end
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_idx   = enc_idx;
        out_last  = enc_one_hot;
        out_seq   = seq_q;
        if (out_ready) begin
          pend_d = pend_q & (pend_q - PEND_ONE);
          seq_d  = seq_q + SEQ_ONE;
          if (enc_one_hot) state_d = IDLE;
        end
      end
      ZERO: begin
        out_valid = 1'b1;
        out_empty = 1'b1;
        out_last  = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_set_bit_enumerator.sv
// Randomized bench for set_bit_enumerator against a queue model.
// Inputs driven and outputs sampled on the falling edge.
module tb_set_bit_enumerator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mask;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        out_empty;
  logic [5:0]  out_seq;

  int errs   = 0;
  int checks = 0;

  set_bit_enumerator dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_empty (out_empty),
    .out_seq   (out_seq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present mask m, then drain all beats with random backpressure
  // (hold_pct = chance of out_ready low). If busy_next is set, a
  // second mask is offered during the drain and must be held off.
  task automatic send(input logic [31:0] m, input int hold_pct,
                      input bit busy_next, input logic [31:0] nxt);
    int q[$];
    int n;
    int beat;
    int cyc;
    bit empty;
    for (int i = 0; i < 32; i++) if (m[i]) q.push_back(i);
    empty = (q.size() == 0);
    n = empty ? 1 : q.size();
    chk("in_ready_idle", 32'(in_ready), 1);
    chk("out_valid_idle", 32'(out_valid), 0);
    in_valid = 1'b1;
    in_mask  = m;
    @(negedge clk);
    if (busy_next) in_mask = nxt;
    else begin
      in_valid = 1'b0;
      in_mask  = $urandom;
    end
    beat = 0;
    cyc  = 0;
    while (beat < n && cyc < 400) begin
      chk("out_valid", 32'(out_valid), 1);
      chk("in_ready_busy", 32'(in_ready), 0);
      chk("out_empty", 32'(out_empty), 32'(empty));
      chk("out_last", 32'(out_last), 32'(beat == n - 1));
      chk("out_seq", 32'(out_seq), empty ? 0 : 32'(beat));
      chk("out_idx", 32'(out_idx), empty ? 0 : 32'(q[beat]));
      out_ready = ($urandom_range(99) >= 32'(hold_pct));
      @(negedge clk);
      if (out_ready) beat++;
      cyc++;
    end
    out_ready = 1'b0;
    if (cyc >= 400) chk("drain_timeout", 32'(beat), 32'(n));
    chk("back_idle_valid", 32'(out_valid), 0);
    chk("back_idle_ready", 32'(in_ready), 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_mask   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_empty", 32'(out_empty), 0);
    chk("rst_out_seq", 32'(out_seq), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_no_beat", 32'(out_valid), 0);
    end
    out_ready = 1'b0;

    send(32'h8000_0005, 0, 0, 0);
    send(32'h0000_0000, 0, 0, 0);
    send(32'h0000_0110, 70, 0, 0);
    send(32'hFFFF_FFFF, 0, 1, 32'h0000_0009);
    send(32'h0000_0009, 30, 0, 0);
    send(32'h8000_0000, 0, 0, 0);

    // Abort an enumeration with reset after two beats.
    in_valid = 1'b1;
    in_mask  = 32'h0000_F000;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("mid_idx0", 32'(out_idx), 12);
    @(negedge clk);
    chk("mid_idx1", 32'(out_idx), 13);
    @(negedge clk);
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_ready", 32'(in_ready), 1);
    chk("mid_rst_seq", 32'(out_seq), 0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_quiet", 32'(out_valid), 0);
    out_ready = 1'b0;
    send(32'h0000_0001, 0, 0, 0);

    for (int k = 0; k < 24; k++) begin
      logic [31:0] m;
      m = $urandom;
      case (k % 4)
        0: m = m & $urandom & $urandom;
        1: m = (k % 8 == 1) ? 32'h0 : m;
        default: ;
      endcase
      send(m, int'($urandom_range(60)), 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/set_bit_enumerator.md
Name: set_bit_enumerator

Overview:
- Inverse of the 32-bit bitwise OR merge in the processor datapath. The OR combines one-hot request bits into a single word; this block splits a merged 32-bit mask back into its individual set-bit indices.
- Emits one index per accepted handshake, lowest bit first.
- Used by the processor to walk register-list and interrupt-pending masks.
- Sits between a mask producer (ALU/OR result) and a sequential consumer, using valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, mask width in bits.
- IDX_W, 5, index width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents a mask.
- in_ready  output  1  block can accept a mask (IDLE only).
- in_mask  input  WIDTH  mask to enumerate.
- out_valid  output  1  out_idx/out_last/out_empty are valid.
- out_ready  input  1  consumer accepts the current beat.
- out_idx  output  IDX_W  index of the lowest remaining set bit; 0 when out_empty.
- out_last  output  1  current beat is the final beat for this mask.
- out_empty  output  1  mask was all-zero; single beat, no index.
- out_seq  output  IDX_W+1  ordinal of the current beat within the mask, 0-based.

Behaviour:
- Reset:
  - Reset is synchronous and active-high; one clock, clk.
  - With rst high at a rising edge: state=IDLE, pending=0, seq=0.
  - Outputs after reset: in_ready=1, out_valid=0, out_idx=0, out_last=0, out_empty=0, out_seq=0.
  - Reset mid-enumeration discards the pending mask; no further beats are emitted.
- States: IDLE, EMIT, ZERO.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid and in_mask!=0: pending<=in_mask, seq<=0, go to EMIT.
  - On in_valid and in_mask==0: go to ZERO.
- EMIT:
  - in_ready=0, out_valid=1.
  - out_idx = priority-encode(lowest set bit of pending).
  - out_last = (pending has exactly one bit set), i.e. (pending & (pending-1))==0.
  - out_seq=seq.
  - On out_ready: clear the lowest set bit (pending <= pending & (pending-1)) and seq<=seq+1. If out_last, go to IDLE.
  - Without out_ready: all outputs stay stable; pending and seq are unchanged.
- ZERO:
  - out_valid=1, out_empty=1, out_last=1, out_idx=0, out_seq=0.
  - On out_ready: go to IDLE.
- Latency: the first beat is valid the cycle after input acceptance.
- Throughput:
  - One index per cycle while out_ready is held high.
  - One bubble cycle between consecutive masks, because in_ready is asserted only in IDLE.
- No combinational path from in_* or out_ready to any output; outputs depend only on registers.
- Full mask 0xFFFFFFFF: 32 beats, indices 0..31; out_seq reaches 31 on the last beat. seq needs IDX_W+1 bits because it briefly holds 32 after the final accept.
- Bit 31 only: one beat, idx=31, last=1.
- in_valid while not IDLE is ignored; the producer must hold it until in_ready.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, EMIT=2'd1, ZERO=2'd2);
  - WIDTH/IDX_W defaults.
- One sub-module, lsb_encoder32: purely combinational lowest-set-bit priority encoder.
  - Input: WIDTH-bit vector.
  - Outputs: IDX_W index and a one_hot flag (exactly one bit set).
- FSM, pending register and seq counter live in the top module.

Test Plan:
- Reset then idle: rst high 2 cycles -> in_ready=1, out_valid=0, out_idx=0; no beats with in_valid=0.
- Load 0x80000005 with out_ready=1 constant -> beats idx 0,2,31; seq 0,1,2; out_last only on idx 31; in_ready back to 1 the next cycle.
- Load 0x00000000 -> exactly one beat: out_empty=1, out_last=1, out_idx=0; then IDLE.
- Backpressure: load 0x00000110, hold out_ready=0 for 3 cycles -> idx=4 stays stable. Then toggle out_ready -> idx 4 then 8, with no beat lost or repeated.
- Load 0xFFFFFFFF with out_ready=1 -> 32 consecutive beats idx 0..31 with seq equal to idx; last on beat 32. A second mask presented during this time is held off (in_ready=0).
- Reset mid-operation: load 0x0000F000, accept 2 beats, assert rst -> next cycle out_valid=0, in_ready=1. A new mask 0x1 then yields a single beat idx=0.
